// File: rtl/jk_pkg.sv
// Shared definitions for the J-K bank driver: command codes, FSM states,
// and the J-K excitation table.
package jk_pkg;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_COUNT = 1'b1
    } op_t;

    // Returns {j,k} moving one flip-flop from cur to nxt; dc picks how the
    // don't-care slot is filled (0: HOLD/SET/RESET, 1: TOGGLE/SET/RESET).
    function automatic logic [1:0] excite(input logic cur, input logic nxt, input logic dc);
        logic [1:0] cmd;
        case ({cur, nxt})
            2'b00:   cmd = dc ? CMD_RESET  : CMD_HOLD;
            2'b01:   cmd = dc ? CMD_TOGGLE : CMD_SET;
            2'b10:   cmd = dc ? CMD_TOGGLE : CMD_RESET;
            default: cmd = dc ? CMD_SET    : CMD_HOLD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational excitation for one J-K flip-flop: the {j,k} command that
// takes it from its current value to the wanted next value.
module jk_excite
    import jk_pkg::*;
#(
    parameter int DC_FILL = 0
) (
    input  logic cur_i,
    input  logic nxt_i,
    output logic j_o,
    output logic k_o
);

    assign {j_o, k_o} = excite(cur_i, nxt_i, DC_FILL != 0);

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of external J-K flip-flops toward a target word and checks
// the bank's fed-back state against an internal shadow model.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DC_FILL = 0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             tgt_op,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             jk_valid,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] shadow_q,
    output logic [WIDTH-1:0] step_cnt,
    output logic             done,
    output logic             err
);

    state_t           state_q;
    op_t              op_q;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] nxt_q;
    logic [WIDTH-1:0] model_q;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic             jkv_q;
    logic             ready_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;

    // The next bank value is only consumed when entering DRIVE: from IDLE it
    // depends on the incoming request, from CHECK it is always a COUNT step.
    always_comb begin
        nxt_d = model_q + WIDTH'(1);
        if (state_q == ST_IDLE && op_t'(tgt_op) == OP_LOAD) begin
            nxt_d = tgt_data;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_excite
        jk_excite #(.DC_FILL(DC_FILL)) u_excite (
            .cur_i (model_q[i]),
            .nxt_i (nxt_d[i]),
            .j_o   (j_d[i]),
            .k_o   (k_d[i])
        );
    end

    // NOTE: every register here uses non-blocking assignment so all of them
    // see the pre-edge values of each other, regardless of statement order.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            tgt_q   <= '0;
            nxt_q   <= '0;
            model_q <= '0;
            step_q  <= '0;
            j_q     <= '0;
            k_q     <= '0;
            jkv_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: pulse-style outputs default low each cycle and are raised
            // only on the transition that needs them.
            j_q     <= '0;
            k_q     <= '0;
            jkv_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (tgt_valid && ready_q) begin
                        op_q    <= op_t'(tgt_op);
                        tgt_q   <= tgt_data;
                        step_q  <= '0;
                        ready_q <= 1'b0;
                        if (op_t'(tgt_op) == OP_COUNT && tgt_data == model_q) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DRIVE;
                            nxt_q   <= nxt_d;
                            j_q     <= j_d;
                            k_q     <= k_d;
                            jkv_q   <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    // The external bank updates on this same edge.
                    model_q <= nxt_q;
                    step_q  <= step_q + WIDTH'(1);
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (q_fb != model_q) begin
                        err_q   <= 1'b1;
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else if (op_q == OP_LOAD || model_q == tgt_q) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRIVE;
                        nxt_q   <= nxt_d;
                        j_q     <= j_d;
                        k_q     <= k_d;
                        jkv_q   <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tgt_ready = ready_q;
    assign j         = j_q;
    assign k         = k_q;
    assign jk_valid  = jkv_q;
    assign shadow_q  = model_q;
    assign step_cnt  = step_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
